// File: rtl/spi_flash_seq.sv
// Flash command sequencer: turns a read/program/erase request into WREN, operation
// and RDSR-poll transactions on spi_master_fl, then returns one response per request.
module spi_flash_seq #(
  parameter int unsigned POLL_MAX    = 1024,
  parameter int unsigned ACK_TIMEOUT = 256,
  parameter logic [7:0]  CMD_WREN    = 8'h06,
  parameter logic [7:0]  CMD_PP      = 8'h02,
  parameter logic [7:0]  CMD_READ    = 8'h03,
  parameter logic [7:0]  CMD_SE      = 8'h20,
  parameter logic [7:0]  CMD_RDSR    = 8'h05
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] spi_data_in,
  output logic [23:0] spi_address,
  output logic [7:0]  spi_command,
  output logic [2:0]  spi_commtype,
  output logic        spi_validflag,
  input  logic        spi_tready,
  input  logic [31:0] spi_data_out,
  input  logic        spi_validflag_out
);

  localparam int unsigned PCW = $clog2(POLL_MAX + 1);
  localparam int unsigned TW  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE, WREN_ISS, WREN_WAIT, OP_ISS, OP_WAIT, POLL_ISS, POLL_WAIT, RESP
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [23:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          acked_q, acked_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [2:0]    ct_q, ct_d;
  logic [23:0]   saddr_q, saddr_d;
  logic [31:0]   sdata_q, sdata_d;
  logic          svf_q, svf_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          capture_type;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      poll_cnt_q <= '0;
      tmr_q      <= '0;
      acked_q    <= 1'b0;
      cmd_q      <= '0;
      ct_q       <= '0;
      saddr_q    <= '0;
      sdata_q    <= '0;
      svf_q      <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      poll_cnt_q <= poll_cnt_d;
      tmr_q      <= tmr_d;
      acked_q    <= acked_d;
      cmd_q      <= cmd_d;
      ct_q       <= ct_d;
      saddr_q    <= saddr_d;
      sdata_q    <= sdata_d;
      svf_q      <= svf_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Only RDSR (001) and READ (010) return data; everything else completes on tready.
  assign capture_type = (ct_q == 3'b001) || (ct_q == 3'b010);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    poll_cnt_d = poll_cnt_q;
    tmr_d      = tmr_q;
    acked_d    = acked_q;
    cmd_d      = cmd_q;
    ct_d       = ct_q;
    saddr_d    = saddr_q;
    sdata_d    = sdata_q;
    svf_d      = 1'b0;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        op_d       = req_op;
        addr_d     = req_addr;
        wdata_d    = req_wdata;
        poll_cnt_d = '0;
        case (req_op)
          2'd0:       state_d = OP_ISS;
          2'd1, 2'd2: state_d = WREN_ISS;
          default: begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        endcase
      end
      WREN_ISS, OP_ISS, POLL_ISS: if (spi_tready) begin
        svf_d   = 1'b1;
        tmr_d   = TW'(ACK_TIMEOUT - 1);
        acked_d = 1'b0;
        saddr_d = '0;
        sdata_d = '0;
        if (state_q == WREN_ISS) begin
          cmd_d   = CMD_WREN;
          ct_d    = 3'b000;
          state_d = WREN_WAIT;
        end else if (state_q == POLL_ISS) begin
          cmd_d      = CMD_RDSR;
          ct_d       = 3'b001;
          poll_cnt_d = poll_cnt_q + PCW'(1);
          state_d    = POLL_WAIT;
        end else begin
          saddr_d = addr_q;
          state_d = OP_WAIT;
          case (op_q)
            2'd0: begin cmd_d = CMD_READ; ct_d = 3'b010; end
            2'd1: begin cmd_d = CMD_PP;   ct_d = 3'b100; sdata_d = wdata_q; end
            default: begin cmd_d = CMD_SE; ct_d = 3'b101; end
          endcase
        end
      end
      WREN_WAIT, OP_WAIT, POLL_WAIT: begin
        if (!acked_q) begin
          if (!spi_tready) acked_d = 1'b1;
          else if (tmr_q == '0) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else tmr_d = tmr_q - TW'(1);
        end else if (capture_type) begin
          if (spi_validflag_out) begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b0;
            if (state_q == OP_WAIT) rdata_d = spi_data_out;
            else if (spi_data_out[0]) begin
              if (poll_cnt_q == PCW'(POLL_MAX)) err_d = 1'b1;
              else state_d = POLL_ISS;
            end
          end
        end else if (spi_tready) begin
          state_d = (state_q == WREN_WAIT) ? OP_ISS : POLL_ISS;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == IDLE);
    busy          = (state_q != IDLE);
    rsp_valid     = (state_q == RESP);
    rsp_rdata     = rdata_q;
    rsp_err       = err_q;
    spi_command   = cmd_q;
    spi_commtype  = ct_q;
    spi_address   = saddr_q;
    spi_data_in   = sdata_q;
    spi_validflag = svf_q;
  end

endmodule
